// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch front end.
//   Owns the fetch PC, issues 1-cycle synchronous reads to program memory,
//   buffers returned instructions with their PCs in a DEPTH-entry FIFO and
//   presents the head downstream over a valid/ready handshake.
// Ports:
//   clk, reset (sync, active-low)
//   stall            - freezes request issue and dequeue
//   redirect_valid/redirect_pc - taken branch/jump; flushes and retargets
//   imem_req/imem_addr/imem_rdata - program memory, rdata one cycle after req
//   id_valid/id_ready/id_instr/id_pc - downstream handshake
//   q_count          - current FIFO occupancy
module if_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic          discard_q, discard_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc_mem_d    [DEPTH];

  logic [CW-1:0] occ;
  logic          wr_en, rd_en;
  logic [31:0]   resp_pc;

  always_comb begin
    // Credits: queued entries plus the one response still on its way.
    occ       = count_q + CW'(inflight_q);
    imem_req  = reset && !stall && !redirect_valid && (occ < CW'(DEPTH));
    imem_addr = fetch_pc_q;

    // fetch_pc only moves by +4 while a request is in flight (a redirect
    // in that cycle would have blocked the issue), so the in-flight PC is
    // recoverable without a separate register.
    resp_pc = fetch_pc_q - 32'd4;

    id_valid = (count_q != '0);
    id_instr = id_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    id_pc    = id_valid ? pc_mem_q[rd_ptr_q]    : 32'h0;
    q_count  = count_q;

    // Response write is independent of stall; a redirect drops it.
    wr_en = inflight_q && !discard_q && !redirect_valid;
    rd_en = id_valid && id_ready && !stall && !redirect_valid;

    fetch_pc_d  = fetch_pc_q;
    inflight_d  = imem_req;
    discard_d   = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    if (redirect_valid) begin
      // Flush everything and retarget; any outstanding response is stale.
      fetch_pc_d = redirect_pc & ~32'h3;
      discard_d  = inflight_q;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (imem_req) fetch_pc_d = fetch_pc_q + 32'd4;
      if (wr_en) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]    = resp_pc;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible when count_q != 0.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed + lightly randomized bench for if_fetch_queue. A scoreboard queue
// holds the PCs of every issued request (queued or in flight); it is flushed
// on redirect/reset and popped on each accepted dequeue.
module tb_if_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
  logic [2:0]  q_count;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Program memory: returns addr>>2 one cycle after a request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr >> 2;
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  int          n_cmp = 0, n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;
  int          infl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at a negedge, drives inputs, checks, models the
  // upcoming posedge, and returns at the following negedge.
  task automatic cyc(input logic rst, input logic stl, input logic rv,
                     input logic [31:0] rpc, input logic rdy);
    logic exp_req, deq;
    int   cnt;
    reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    #1;
    cnt     = sb.size() - infl;
    exp_req = rst && !stl && !rv && (sb.size() < DEPTH);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_pc);
    chk("q_count", {29'b0, q_count}, 32'(cnt));
    chk("id_valid", {31'b0, id_valid}, {31'b0, cnt != 0});
    if (cnt > 0) begin
      chk("id_pc", id_pc, sb[0]);
      chk("id_instr", id_instr, sb[0] >> 2);
    end else begin
      chk("id_pc_empty", id_pc, 32'h0);
      chk("id_instr_empty", id_instr, NOP);
    end
    deq = rst && !rv && !stl && rdy && (cnt > 0);
    if (!rst) begin
      sb.delete(); infl = 0; exp_pc = 32'h0;
    end else if (rv) begin
      sb.delete(); infl = 0; exp_pc = rpc & ~32'h3;
    end else begin
      if (deq) void'(sb.pop_front());
      if (exp_req) begin
        sb.push_back(exp_pc); exp_pc = exp_pc + 32'd4; infl = 1;
      end else infl = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Initial reset: DUT state is unknown until the first edge.
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    sb.delete(); infl = 0; exp_pc = 32'h0;

    // 1. Reset release, streaming with id_ready high.
    cyc(0, 0, 0, 0, 1);
    chk("rst_q_count", {29'b0, q_count}, 32'h0);
    chk("rst_id_instr", id_instr, NOP);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 1);

    // 2. Backpressure from a fresh reset.
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0);
    chk("bp_full", {29'b0, q_count}, 32'h4);
    chk("bp_head", id_pc, 32'h0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 1);

    // 3. Redirect while a request is in flight.
    cyc(1, 0, 1, 32'h103, 1);
    chk("rd_flush", {29'b0, q_count}, 32'h0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("rd_target_vis", id_pc, 32'h100);
    chk("rd_target_instr", id_instr, 32'h40);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1);

    // 4. Three-cycle stall mid-stream.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);

    // 5. Redirect and stall together, then stall alone, then resume.
    cyc(1, 1, 1, 32'h200, 1);
    chk("rs_flush", {29'b0, q_count}, 32'h0);
    cyc(1, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);

    // Randomized ready/stall mix with occasional redirects.
    for (int i = 0; i < 60; i++)
      cyc(1, ($urandom_range(0, 4) == 0), ($urandom_range(0, 15) == 0),
          $urandom & 32'h0000_0FFF, 1'($urandom_range(0, 1)));

    // 6. Address wrap, then reset mid-stream.
    cyc(1, 0, 1, 32'hFFFF_FFF8, 1);
    chk("wr_addr0", imem_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("mid_rst_q", {29'b0, q_count}, 32'h0);
    chk("mid_rst_valid", {31'b0, id_valid}, 32'h0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
